// File: rtl/bc_pkg.sv
// Shared types for the Bulls & Cows display path: board defaults, the
// per-row record written to the board register file, and controller states.
package bc_pkg;

   localparam int ROWS_DEF   = 8;
   localparam int DIGITS_DEF = 4;

   typedef struct packed {
      logic [4*DIGITS_DEF-1:0]         guess;
      logic [$clog2(DIGITS_DEF+1)-1:0] bulls;
      logic [$clog2(DIGITS_DEF+1)-1:0] cows;
   } row_rec_t;

   typedef enum logic [3:0] {
      IDLE,
      WAIT_VBL,
      COMMIT,
      REQ_FRAME,
      WAIT_ACK,
      ACK,
      FINAL_REQ,
      FINAL_WAIT,
      DONE
   } fuc_state_t;

endpackage

// File: rtl/frame_update_ctrl_edge_det.sv
// Registered falling-edge detector; the history register resets to 1 so a
// signal that is low when reset releases is not seen as an edge.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic fall
);

   logic din_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) din_q <= 1'b1;
      else      din_q <= din;
   end

   assign fall = din_q & ~din;

endmodule

// File: rtl/frame_update_ctrl.sv
// Solver-to-renderer update sequencer: commits one row inside vertical blanking,
// then handshakes a frame capture. Optional macro FRAME_TIMEOUT_EN bounds that wait.
module frame_update_ctrl
   import bc_pkg::*;
#(
   parameter int ROWS    = ROWS_DEF,
   parameter int DIGITS  = DIGITS_DEF,
`ifdef FRAME_TIMEOUT_EN
   parameter int TIMEOUT = 1_000_000,
`endif
   localparam int RW = $clog2(ROWS),
   localparam int CW = $clog2(DIGITS+1),
   localparam int DW = 4*DIGITS + 2*CW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              upd_req,
   input  logic [RW-1:0]     upd_row,
   input  logic [4*DIGITS-1:0] upd_guess,
   input  logic [CW-1:0]     upd_bulls,
   input  logic [CW-1:0]     upd_cows,
   output logic              upd_ack,
   input  logic              solved,
   input  logic              vsync,
   output logic              brd_we,
   output logic [RW-1:0]     brd_addr,
   output logic [DW-1:0]     brd_data,
   output logic              write_frame,
   input  logic              frame_written,
   output logic              done,
   output logic              err,
   output fuc_state_t        dbg_state
);

   typedef struct packed {
      logic [4*DIGITS-1:0] guess;
      logic [CW-1:0]       bulls;
      logic [CW-1:0]       cows;
   } rec_t;

   fuc_state_t    state;
   fuc_state_t    state_nxt;
   logic [RW-1:0] row_q;
   rec_t          rec_q;
   logic          err_q;
   logic          err_set;
   logic          vbl_start;
   logic          row_ok;
   logic          expired;

   edge_det u_vbl (
      .clk  (clk),
      .rst  (rst),
      .din  (vsync),
      .fall (vbl_start)
   );

   assign row_ok = (32'(row_q) < ROWS);

`ifdef FRAME_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT);

   logic [TW-1:0] wait_cnt;
   logic          in_wait;

   assign in_wait = (state == WAIT_ACK) || (state == FINAL_WAIT);

   // Held at zero outside the wait states, so every wait starts from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         wait_cnt <= '0;
      else if (in_wait) wait_cnt <= wait_cnt + TW'(1);
      else              wait_cnt <= '0;
   end

   assign expired = in_wait && (wait_cnt == TW'(TIMEOUT-1));
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         row_q <= '0;
         rec_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && upd_req) begin
            row_q <= upd_row;
            rec_q <= '{guess: upd_guess, bulls: upd_bulls, cows: upd_cows};
         end
         if (err_set) err_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      err_set   = 1'b0;
      case (state)
         IDLE: begin
            // A pending row wins over solved; solved is seen again once back here.
            if (upd_req)     state_nxt = WAIT_VBL;
            else if (solved) state_nxt = FINAL_REQ;
         end
         WAIT_VBL: if (vbl_start) state_nxt = COMMIT;
         COMMIT: begin
            if (row_ok) begin
               state_nxt = REQ_FRAME;
            end else begin
               err_set   = 1'b1;
               state_nxt = ACK;
            end
         end
         REQ_FRAME: state_nxt = WAIT_ACK;
         WAIT_ACK: begin
            if (frame_written) begin
               state_nxt = ACK;
            end else if (expired) begin
               err_set   = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK:       state_nxt = IDLE;
         FINAL_REQ: state_nxt = FINAL_WAIT;
         FINAL_WAIT: begin
            if (frame_written) begin
               state_nxt = DONE;
            end else if (expired) begin
               err_set   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode the state register only, so reset clears them at once.
   assign brd_we      = (state == COMMIT) && row_ok;
   assign brd_addr    = row_q;
   assign brd_data    = rec_q;
   assign write_frame = (state == REQ_FRAME) || (state == WAIT_ACK) ||
                        (state == FINAL_REQ) || (state == FINAL_WAIT);
   assign upd_ack     = (state == ACK);
   assign done        = (state == DONE);
   assign err         = err_q;
   assign dbg_state   = state;

endmodule

// File: tb/tb_frame_update_ctrl.sv
// Self-checking bench for frame_update_ctrl: a procedural protocol model predicts
// every output each cycle; directed tests pin the model with literal values.
module tb_frame_update_ctrl;
   import bc_pkg::*;

   localparam int ROWS   = 6;
   localparam int DIGITS = 4;
   localparam int RW     = $clog2(ROWS);
   localparam int CW     = $clog2(DIGITS+1);
   localparam int DW     = 4*DIGITS + 2*CW;
`ifdef FRAME_TIMEOUT_EN
   localparam int TIMEOUT = 100;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              upd_req = 1'b0;
   logic [RW-1:0]     upd_row = '0;
   logic [4*DIGITS-1:0] upd_guess = '0;
   logic [CW-1:0]     upd_bulls = '0;
   logic [CW-1:0]     upd_cows = '0;
   logic              solved = 1'b0;
   logic              vsync = 1'b1;
   logic              frame_written = 1'b0;
   logic              upd_ack;
   logic              brd_we;
   logic [RW-1:0]     brd_addr;
   logic [DW-1:0]     brd_data;
   logic              write_frame;
   logic              done;
   logic              err;
   fuc_state_t        dbg_state;

   frame_update_ctrl #(
      .ROWS    (ROWS),
`ifdef FRAME_TIMEOUT_EN
      .TIMEOUT (TIMEOUT),
`endif
      .DIGITS  (DIGITS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .upd_req       (upd_req),
      .upd_row       (upd_row),
      .upd_guess     (upd_guess),
      .upd_bulls     (upd_bulls),
      .upd_cows      (upd_cows),
      .upd_ack       (upd_ack),
      .solved        (solved),
      .vsync         (vsync),
      .brd_we        (brd_we),
      .brd_addr      (brd_addr),
      .brd_data      (brd_data),
      .write_frame   (write_frame),
      .frame_written (frame_written),
      .done          (done),
      .err           (err),
      .dbg_state     (dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ack_cnt = 0;
   int we_cnt = 0;
   int wf_cnt = 0;
   int wf_rise = 0;
   logic wf_prev = 1'b0;

   bit vs_auto = 1'b0;
   int fw_mode = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic          exp_we = 1'b0;
   logic          exp_wf = 1'b0;
   logic          exp_ack = 1'b0;
   logic          m_done = 1'b0;
   logic          m_err = 1'b0;
   logic [RW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_data = '0;
   bit            aborted = 1'b0;
   bit            m_vs_prev = 1'b1;
   bit            m_fall = 1'b0;

   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         aborted   = 1'b1;
         m_vs_prev = 1'b1;
         m_fall    = 1'b0;
      end else begin
         m_fall    = m_vs_prev & ~vsync;
         m_vs_prev = vsync;
      end
   endtask

   task automatic m_clear();
      aborted = 1'b0;
      m_err   = 1'b0;
      m_done  = 1'b0;
      exp_we  = 1'b0;
      exp_wf  = 1'b0;
      exp_ack = 1'b0;
   endtask

   // Waits for the capture side; hit=0 means the wait was abandoned.
   task automatic wait_frame(output bit hit);
      hit = 1'b0;
`ifdef FRAME_TIMEOUT_EN
      for (int k = 0; k < TIMEOUT; k++) begin
         tick();
         if (aborted) return;
         if (frame_written) begin
            hit = 1'b1;
            return;
         end
      end
`else
      forever begin
         tick();
         if (aborted) return;
         if (frame_written) begin
            hit = 1'b1;
            return;
         end
      end
`endif
   endtask

   task automatic model_update();
      logic [RW-1:0] r;
      row_rec_t      rec;
      bit            hit;
      r         = upd_row;
      rec.guess = upd_guess;
      rec.bulls = upd_bulls;
      rec.cows  = upd_cows;
      do begin
         tick();
         if (aborted) return;
      end while (!m_fall);
      if (int'(r) < ROWS) begin
         exp_we   = 1'b1;
         exp_addr = r;
         exp_data = rec;
      end
      tick();
      if (aborted) return;
      exp_we = 1'b0;
      if (int'(r) < ROWS) begin
         exp_wf = 1'b1;
         tick();
         if (aborted) return;
         wait_frame(hit);
         if (aborted) return;
         exp_wf = 1'b0;
         if (!hit) m_err = 1'b1;
      end else begin
         m_err = 1'b1;
      end
      exp_ack = 1'b1;
      tick();
      if (aborted) return;
      exp_ack = 1'b0;
   endtask

   task automatic model_final();
      bit hit;
      exp_wf = 1'b1;
      tick();
      if (aborted) return;
      wait_frame(hit);
      if (aborted) return;
      exp_wf = 1'b0;
      if (!hit) m_err = 1'b1;
      m_done = 1'b1;
   endtask

   initial begin : model
      m_clear();
      forever begin
         exp_we  = 1'b0;
         exp_wf  = 1'b0;
         exp_ack = 1'b0;
         tick();
         if (!aborted && !m_done) begin
            if (upd_req)     model_update();
            else if (solved) model_final();
         end
         if (aborted) m_clear();
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         chk("reset_outputs", 32'({upd_ack, brd_we, write_frame, done, err}), 32'd0);
      end else begin
         chk("brd_we", 32'(brd_we), 32'(exp_we));
         chk("write_frame", 32'(write_frame), 32'(exp_wf));
         chk("upd_ack", 32'(upd_ack), 32'(exp_ack));
         chk("done", 32'(done), 32'(m_done));
         chk("err", 32'(err), 32'(m_err));
         if (exp_we) begin
            chk("brd_addr", 32'(brd_addr), 32'(exp_addr));
            chk("brd_data", 32'(brd_data), 32'(exp_data));
         end
         if (upd_ack) ack_cnt++;
         if (brd_we) we_cnt++;
         if (write_frame) wf_cnt++;
         if (write_frame && !wf_prev) wf_rise++;
      end
      wf_prev = write_frame;
   end

   // ---------------- stimulus generators ----------------
   initial begin : vs_gen
      int vs_cnt;
      vs_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (vs_auto) begin
            if (vs_cnt == 0) begin
               vsync  = ~vsync;
               vs_cnt = vsync ? $urandom_range(40, 15) : $urandom_range(4, 1);
            end else begin
               vs_cnt--;
            end
         end
      end
   end

   initial begin : fw_gen
      int d;
      d = 0;
      forever begin
         @(posedge clk);
         #1;
         if (fw_mode == 1) begin
            if (write_frame) begin
               if (d == 0) frame_written = 1'b1;
               else begin
                  d--;
                  frame_written = 1'b0;
               end
            end else begin
               frame_written = 1'b0;
               d = $urandom_range(12, 0);
            end
         end else if (fw_mode == 2) begin
            frame_written = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ack(input int budget);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         if (upd_ack) seen = 1'b1;
         else if (n == 2) begin
            upd_guess = 16'($urandom);
            upd_row   = RW'($urandom);
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL ack_wait: got no upd_ack expected one within %0d cycles", budget);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_row(input logic [RW-1:0] r, input logic [15:0] g,
                           input logic [CW-1:0] b, input logic [CW-1:0] c, input int budget);
      @(posedge clk);
      #1;
      upd_req   = 1'b1;
      upd_row   = r;
      upd_guess = g;
      upd_bulls = b;
      upd_cows  = c;
      wait_ack(budget);
      upd_req = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin : watchdog
      #600000;
      failures++;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int a0, w0, f0, r0, n;
      logic [15:0] g;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("reset_state", 32'(dbg_state), 32'(IDLE));
      chk("reset_done_err", 32'({done, err}), 32'd0);

      // Row 0 with a vsync fall placed near cycle 50.
      a0 = ack_cnt;
      @(posedge clk);
      #1;
      upd_req = 1'b1; upd_row = 0; upd_guess = 16'h1234; upd_bulls = 1; upd_cows = 2;
      while (cyc < 50) @(posedge clk);
      #1;
      vsync = 1'b0;
      @(negedge clk);
      chk("t1_we_before_edge", 32'(brd_we), 32'd0);
      @(negedge clk);
      chk("t1_we", 32'(brd_we), 32'd1);
      chk("t1_addr", 32'(brd_addr), 32'd0);
      chk("t1_data", 32'(brd_data), 32'h048D0A);
      @(negedge clk);
      chk("t1_wf_rise", 32'(write_frame), 32'd1);
      repeat (10) @(posedge clk);
      #1;
      frame_written = 1'b1;
      @(posedge clk);
      #1;
      frame_written = 1'b0;
      @(negedge clk);
      chk("t1_wf_drop", 32'(write_frame), 32'd0);
      chk("t1_ack", 32'(upd_ack), 32'd1);
      @(posedge clk);
      #1;
      upd_req = 1'b0;
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("t1_ack_once", 32'(ack_cnt - a0), 32'd1);

      // No vsync edge for 10k cycles: the row stays parked.
      w0 = we_cnt; f0 = wf_cnt;
      @(posedge clk);
      #1;
      upd_req = 1'b1; upd_row = 2; upd_guess = 16'h9876; upd_bulls = 0; upd_cows = 4;
      repeat (10000) @(posedge clk);
      @(negedge clk);
      #1;
      chk("novbl_state", 32'(dbg_state), 32'(WAIT_VBL));
      chk("novbl_we", 32'(we_cnt - w0), 32'd0);
      chk("novbl_wf", 32'(wf_cnt - f0), 32'd0);
      fw_mode = 1;
      vs_auto = 1'b1;
      wait_ack(500);
      upd_req = 1'b0;

      // Out-of-range row: error, ack, no write, no frame.
      a0 = ack_cnt; w0 = we_cnt; f0 = wf_cnt;
      send_row(3'd7, 16'h4321, 0, 0, 500);
      repeat (2) @(negedge clk);
      #1;
      chk("oor_err", 32'(err), 32'd1);
      chk("oor_we", 32'(we_cnt - w0), 32'd0);
      chk("oor_wf", 32'(wf_cnt - f0), 32'd0);
      chk("oor_ack", 32'(ack_cnt - a0), 32'd1);

      // Reset while write_frame is high drops outputs without a clock edge.
      fw_mode = 0;
      frame_written = 1'b0;
      @(posedge clk);
      #1;
      upd_req = 1'b1; upd_row = 4; upd_guess = 16'h5555; upd_bulls = 2; upd_cows = 2;
      n = 0;
      while (!write_frame && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_wf_seen", 32'(write_frame), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_async_wf", 32'(write_frame), 32'd0);
      chk("rst_async_done", 32'(done), 32'd0);
      chk("rst_async_ack", 32'(upd_ack), 32'd0);
      chk("rst_async_err", 32'(err), 32'd0);
      upd_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

`ifdef FRAME_TIMEOUT_EN
      // Capture side never answers: the wait is abandoned after TIMEOUT cycles.
      a0 = ack_cnt; f0 = wf_cnt;
      send_row(3'd1, 16'h2468, 1, 1, 2000);
      repeat (2) @(negedge clk);
      #1;
      chk("tmo_wf_cycles", 32'(wf_cnt - f0), 32'(TIMEOUT + 1));
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_ack", 32'(ack_cnt - a0), 32'd1);
      do_reset();
`endif

      // Randomized rows, capture latencies and idle gaps.
      for (int t = 0; t < 30; t++) begin
         for (int dgt = 0; dgt < 4; dgt++) g[dgt*4 +: 4] = 4'($urandom_range(9, 0));
         fw_mode = ($urandom_range(3, 0) == 0) ? 2 : 1;
         send_row(RW'($urandom_range(7, 0)), g, CW'($urandom_range(4, 0)),
                  CW'($urandom_range(4, 0)), 500);
         repeat ($urandom_range(3, 0)) @(posedge clk);
      end
      fw_mode = 1;

      // Row and solved together: row first, then the final frame.
      a0 = ack_cnt; r0 = wf_rise;
      @(posedge clk);
      #1;
      upd_req = 1'b1; solved = 1'b1; upd_row = 3; upd_guess = 16'h5678; upd_bulls = 4; upd_cows = 0;
      wait_ack(500);
      upd_req = 1'b0;
      n = 0;
      while (!done && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("final_done", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      upd_req = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      upd_req = 1'b0;
      @(negedge clk);
      #1;
      chk("final_ack_once", 32'(ack_cnt - a0), 32'd1);
      chk("final_two_frames", 32'(wf_rise - r0), 32'd2);
      chk("final_done_sticky", 32'(done), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("final_rst_done", 32'(done), 32'd0);
      solved = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frame_update_ctrl.md
Name: frame_update_ctrl

Overview:
- Sequences display updates between the Bulls & Cows solver and the VGA board renderer.
- Accepts one guess/score row at a time from the solver and commits it to the board register file only inside vertical blanking.
- Then runs the write_frame / frame_written handshake with the frame-capture side and acknowledges the solver.
- On solve, emits one final frame and raises done; sits between solver and vga_ctrl inside top.

Parameters:
- ROWS, 8, number of guess rows on the board.
- DIGITS, 4, digits per guess (4-bit BCD each).
- TIMEOUT, 1_000_000, clk cycles allowed for frame_written (used only with FRAME_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- upd_req  in  1  solver has a row to display; held until upd_ack.
- upd_row  in  $clog2(ROWS)  board row index.
- upd_guess  in  4*DIGITS  guess, BCD, digit 0 in LSBs.
- upd_bulls  in  $clog2(DIGITS+1)  bulls count.
- upd_cows  in  $clog2(DIGITS+1)  cows count.
- upd_ack  out  1  one-cycle pulse: row committed and frame captured.
- solved  in  1  solver finished (level).
- vsync  in  1  VGA vsync, active-low pulse.
- brd_we  out  1  board register-file write strobe.
- brd_addr  out  $clog2(ROWS)  write row.
- brd_data  out  4*DIGITS+2*$clog2(DIGITS+1)  {guess, bulls, cows}.
- write_frame  out  1  frame capture request (level).
- frame_written  in  1  capture complete.
- done  out  1  sticky, final frame captured.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; vsync_q=1; captured row regs 0; timeout counter 0.
- vsync_q registers vsync each clk; vbl_start = vsync_q & ~vsync (falling edge, one cycle).
- IDLE:
  - upd_req=1: latch row/guess/bulls/cows, go WAIT_VBL.
  - else if solved=1 and done=0: go FINAL_REQ.
  - upd_req has priority when both are high the same cycle; solved is re-checked on return to IDLE.
- WAIT_VBL: wait for vbl_start, then go COMMIT. No timeout.
- COMMIT (1 cycle):
  - brd_we=1, brd_addr=latched row, brd_data={guess,bulls,cows}; go REQ_FRAME.
  - Latched row >= ROWS: no write, err set, go ACK directly.
- REQ_FRAME: write_frame=1; go WAIT_ACK.
- WAIT_ACK:
  - write_frame held 1.
  - frame_written sampled 1: write_frame=0 next cycle, go ACK.
  - frame_written already 1 on entry counts immediately; minimum REQ_FRAME to ACK is 2 cycles.
- ACK: upd_ack=1 for one cycle; go IDLE. Solver must drop or replace upd_req the cycle after ack; a still-high upd_req is treated as a new request.
- FINAL_REQ / FINAL_WAIT:
  - Same write_frame handshake, no board write.
  - On frame_written: done=1 (sticky), go DONE.
- DONE: absorbing. upd_req ignored, write_frame=0. Exit only by reset.
- Inputs upd_* are sampled only in IDLE; changes afterwards are ignored.
- Reset mid-handshake drops write_frame asynchronously; no ack is issued.

Optional Feature:
- FRAME_TIMEOUT_EN defined:
  - Counter runs in WAIT_ACK/FINAL_WAIT.
  - Reaching TIMEOUT-1 without frame_written: write_frame=0, err=1.
  - Update path goes to ACK; final path goes to DONE with done=1.
  - Counter clears on entry to each wait state.
- FRAME_TIMEOUT_EN undefined: wait indefinitely; no counter logic.

Decomposition:
- Package bc_pkg: ROWS/DIGITS defaults, row-record typedef struct {guess, bulls, cows}, state enum fuc_state_t.
- Sub-module edge_det (registered falling-edge detector, reset value 1) is natural; the rest stays flat.

Test Plan:
- Row 0, guess 16'h1234, bulls 1, cows 2; vsync falls at cycle 50:
  - brd_we exactly one cycle after the edge, brd_addr 0, brd_data 22'h048D0A.
  - write_frame rises the next cycle.
  - frame_written at +10 → write_frame drops and upd_ack pulses once.
- upd_req and solved high the same cycle (row 3):
  - Row commit and ack complete first.
  - Then a second write_frame request; done=1 after its frame_written; upd_ack never re-pulses.
- No vsync edge for 10k cycles: brd_we and write_frame stay 0; state remains WAIT_VBL.
- Reset driven low while write_frame=1: write_frame, done, upd_ack go 0 immediately without a clk edge.
- FRAME_TIMEOUT_EN, TIMEOUT=100, frame_written never asserted: write_frame drops after 100 cycles in WAIT_ACK, err=1, upd_ack pulses.
- upd_row=7, ROWS=6 (row out of range): no brd_we, err=1, upd_ack pulses, write_frame never asserted.
